binconv_bn_sign_pack: RTL and testbench

//  - Downstream stage of the binary-convolution popcount kernel.
//  - Accumulates popcount partials across channel groups, giving one full 3x3xD
//    dot product per output channel.
//  - Applies the folded batch-norm/sign activation as an integer threshold

---
 rtl/binconv_bn_sign_pack_pkg.sv | 22 ++
 rtl/binconv_bn_sign_pack_bn_sign_cmp.sv | 14 +
 rtl/binconv_bn_sign_pack.sv | 134 +++++++++++++
 tb/tb_binconv_bn_sign_pack.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/binconv_bn_sign_pack_pkg.sv
// Shared constants and width helpers for the binarized-conv BN/sign/pack stage.
// Layer geometry sets the default popcount partial width.
package binconv_bn_sign_pack_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Grouping counter needs at least one bit even when a channel is a single pass.
  function automatic int grp_width(input int groups);
    return (groups > 1) ? clog2(groups) : 1;
  endfunction

  localparam int LAYER_D    = 512;
  localparam int LAYER_FH   = 3;
  localparam int LAYER_FW   = 3;
  localparam int PSUM_W_DEF = clog2(LAYER_D * LAYER_FH * LAYER_FW + 1);

endpackage

// File: rtl/binconv_bn_sign_pack_bn_sign_cmp.sv
// Folded batch-norm + sign activation as an unsigned threshold compare.
// gamma<0 layers flip the compare direction.
module bn_sign_cmp #(
  parameter int W = 16
) (
  input  logic [W-1:0] sum,
  input  logic [W-1:0] thr,
  input  logic         flip,
  output logic         act
);

  assign act = flip ? (sum < thr) : (sum >= thr);

endmodule

// File: rtl/binconv_bn_sign_pack.sv
// Accumulates popcount partials per output channel, thresholds them to one
// activation bit and packs PACK bits per output word.
module binconv_bn_sign_pack
  import binconv_bn_sign_pack_pkg::*;
#(
  parameter int PSUM_W = PSUM_W_DEF,
  parameter int GROUPS = 1,
  parameter int ACC_W  = 16,
  parameter int PACK   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PSUM_W-1:0]          in_psum,
  input  logic                       in_last,
  input  logic [ACC_W-1:0]           in_thr,
  input  logic                       in_flip,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PACK-1:0]            out_data,
  output logic [clog2(PACK+1)-1:0]   out_nbits
);

  localparam int NB_W  = clog2(PACK + 1);
  localparam int GRP_W = grp_width(GROUPS);
  localparam logic [NB_W-1:0]  LAST_BIT = NB_W'(PACK - 1);
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(GROUPS - 1);

  logic [ACC_W-1:0] acc;
  logic [GRP_W-1:0] grp_cnt;
  logic [NB_W-1:0]  bit_cnt;
  logic [PACK-1:0]  pack_q;
  logic             flush_pend;

  logic             beat;
  logic             held;
  logic [ACC_W-1:0] sum;
  logic             ch_last;
  logic             close;
  logic             act;
  logic [PACK-1:0]  pack_ins;
  logic [NB_W-1:0]  cnt_ins;
  logic             word_full;
  logic             flush_req;
  logic             flush_emit;
  logic             load;

  // Both ports use valid/ready: a transfer happens on a rising clk edge where
  // valid and ready are both high. out_valid/out_data/out_nbits are held
  // stable until taken; in_ready only drops for a beat that would have to
  // overwrite a word the consumer has not yet taken.
  assign held     = out_valid & ~out_ready;
  assign in_ready = ~(held & ((bit_cnt == LAST_BIT) | flush_pend));
  assign beat     = in_valid & in_ready;

  // The first partial of a channel ignores whatever acc holds.
  assign sum     = ((grp_cnt == '0) ? '0 : acc) + ACC_W'(in_psum);
  assign ch_last = in_last | (grp_cnt == LAST_GRP);
  assign close   = beat & ch_last;

  bn_sign_cmp #(
    .W (ACC_W)
  ) u_cmp (
    .sum  (sum),
    .thr  (in_thr),
    .flip (in_flip),
    .act  (act)
  );

  // Packed view including this cycle's bit, so a concurrent flush sees it.
  always_comb begin
    pack_ins = pack_q;
    cnt_ins  = bit_cnt;
    if (close) begin
      pack_ins = pack_q | ({{(PACK-1){1'b0}}, act} << bit_cnt);
      cnt_ins  = bit_cnt + NB_W'(1);
    end
  end

  assign word_full  = close & (bit_cnt == LAST_BIT);
  assign flush_req  = flush | flush_pend;
  assign flush_emit = flush_req & ~held & ~word_full & (cnt_ins != '0);
  assign load       = word_full | flush_emit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      grp_cnt <= '0;
    end else if (beat) begin
      if (ch_last) begin
        grp_cnt <= '0;
      end else begin
        acc     <= sum;
        grp_cnt <= grp_cnt + GRP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q     <= '0;
      bit_cnt    <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (load) begin
        pack_q  <= '0;
        bit_cnt <= '0;
      end else if (close) begin
        pack_q  <= pack_ins;
        bit_cnt <= cnt_ins;
      end
      // A flush that arrives while a word is held waits for that handshake.
      flush_pend <= flush_req & held;
    end
  end

  // A full word and a flushed word share one path: cnt_ins is PACK when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_nbits <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= pack_ins;
      out_nbits <= cnt_ins;
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_binconv_bn_sign_pack.sv
// Bench for binconv_bn_sign_pack (GROUPS=4, PACK=4): directed scenarios plus
// random traffic against a channel/bit-list reference model.
module tb_binconv_bn_sign_pack;
  import binconv_bn_sign_pack_pkg::*;

  localparam int PSUM_W = 13;
  localparam int GROUPS = 4;
  localparam int ACC_W  = 16;
  localparam int PACK   = 4;
  localparam int NB_W   = 3;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [PSUM_W-1:0] in_psum;
  logic              in_last;
  logic [ACC_W-1:0]  in_thr;
  logic              in_flip;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [PACK-1:0]   out_data;
  logic [NB_W-1:0]   out_nbits;

  binconv_bn_sign_pack #(
    .PSUM_W (PSUM_W),
    .GROUPS (GROUPS),
    .ACC_W  (ACC_W),
    .PACK   (PACK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_psum   (in_psum),
    .in_last   (in_last),
    .in_thr    (in_thr),
    .in_flip   (in_flip),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_nbits (out_nbits)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int   ch_q[$];
  bit   bits_q[$];
  logic [NB_W+PACK-1:0] exp_q[$];
  bit   m_pend;
  bit   m_ov;
  int   m_od;
  int   m_on;
  bit   m_rdy;

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pack_bits();
    int w;
    w = 0;
    foreach (bits_q[i]) if (bits_q[i]) w = w | (1 << i);
    return w;
  endfunction

  task automatic model_reset();
    ch_q.delete();
    bits_q.delete();
    exp_q.delete();
    m_pend = 1'b0;
    m_ov   = 1'b0;
    m_od   = 0;
    m_on   = 0;
  endtask

  // Applies one clock edge worth of spec rules to the model.
  task automatic model_step();
    bit held, taken, load, b;
    int s, nd, nn;
    held  = m_ov && !out_ready;
    taken = m_ov && out_ready;
    load  = 1'b0;
    nd    = 0;
    nn    = 0;
    if (in_valid && m_rdy) begin
      ch_q.push_back(int'(in_psum));
      if (in_last || ch_q.size() == GROUPS) begin
        s = ch_q.sum();
        b = in_flip ? (s < int'(in_thr)) : (s >= int'(in_thr));
        ch_q.delete();
        bits_q.push_back(b);
        if (bits_q.size() == PACK) begin
          nd = pack_bits();
          nn = PACK;
          load = 1'b1;
          bits_q.delete();
        end
      end
    end
    if (flush || m_pend) begin
      if (held) begin
        m_pend = 1'b1;
      end else begin
        m_pend = 1'b0;
        if (!load && bits_q.size() > 0) begin
          nd = pack_bits();
          nn = bits_q.size();
          load = 1'b1;
          bits_q.delete();
        end
      end
    end
    if (load) begin
      m_ov = 1'b1;
      m_od = nd;
      m_on = nn;
      exp_q.push_back({NB_W'(nn), PACK'(nd)});
    end else if (taken) begin
      m_ov = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    logic [NB_W+PACK-1:0] e;
    #1;
    m_rdy = !(m_ov && !out_ready && (bits_q.size() == PACK - 1 || m_pend));
    check("in_ready", in_ready, m_rdy);
    if (m_ov && out_ready) begin
      e = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check("word_taken", {out_nbits, out_data}, e);
    end
    @(posedge clk);
    model_step();
    #1;
    check("out_valid", out_valid, m_ov);
    if (m_ov) begin
      check("out_data", out_data, m_od);
      check("out_nbits", out_nbits, m_on);
    end
  endtask

  task automatic drive(input bit v, input int psum, input bit last, input int thr,
                       input bit flp, input bit fl, input bit ordy);
    in_valid  = v;
    in_psum   = PSUM_W'(psum);
    in_last   = last;
    in_thr    = ACC_W'(thr);
    in_flip   = flp;
    flush     = fl;
    out_ready = ordy;
    tick();
  endtask

  task automatic idle(input bit fl, input bit ordy);
    drive(1'b0, 0, 1'b0, 0, 1'b0, fl, ordy);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_psum   = '0;
    in_last   = 1'b0;
    in_thr    = '0;
    in_flip   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, 4'b0000);
    check("reset_out_nbits", out_nbits, 3'd0);
    rst_n = 1'b1;

    // Single-pass channels: 10,3,7,7 vs thr 7 -> 1101
    drive(1, 10, 1, 7, 0, 0, 1);
    drive(1, 3,  1, 7, 0, 0, 1);
    drive(1, 7,  1, 7, 0, 0, 1);
    drive(1, 7,  1, 7, 0, 0, 1);
    check("g1_valid", out_valid, 1'b1);
    check("g1_data", out_data, 4'b1101);
    check("g1_nbits", out_nbits, 3'd4);
    idle(0, 1);

    // Four-group channels summing to 4200, auto-closed after the 4th partial
    begin
      int thr_t[4];
      bit flp_t[4];
      thr_t = '{4200, 4201, 4200, 4201};
      flp_t = '{0, 0, 1, 1};
      for (int c = 0; c < 4; c++) begin
        drive(1, 1000, 0, thr_t[c], flp_t[c], 0, 1);
        drive(1, 1200, 0, thr_t[c], flp_t[c], 0, 1);
        drive(1, 900,  0, thr_t[c], flp_t[c], 0, 1);
        drive(1, 1100, 0, thr_t[c], flp_t[c], 0, 1);
      end
    end
    check("g4_data", out_data, 4'b1001);
    idle(0, 1);

    // Flush after bits 1,0,1, then flush on an empty packer
    drive(1, 10, 1, 7, 0, 0, 0);
    drive(1, 3,  1, 7, 0, 0, 0);
    drive(1, 10, 1, 7, 0, 0, 0);
    idle(1, 0);
    check("flush_data", out_data, 4'b0101);
    check("flush_nbits", out_nbits, 3'd3);
    idle(0, 1);
    idle(1, 1);
    check("flush_empty", out_valid, 1'b0);

    // Backpressure: held word stalls only the 4th bit of the next word
    for (int i = 0; i < 7; i++) drive(1, 10, 1, 7, 0, 0, 0);
    check("bp_stall", in_ready, 1'b0);
    repeat (3) drive(1, 3, 1, 7, 0, 0, 0);
    drive(1, 3, 1, 7, 0, 0, 1);
    check("bp_word2", out_data, 4'b0111);
    idle(0, 1);

    // Flush together with a last beat while a word is held
    for (int i = 0; i < 4; i++) drive(1, 3, 1, 7, 0, 0, 0);
    drive(1, 10, 1, 7, 0, 0, 0);
    drive(1, 3,  1, 7, 0, 1, 0);
    check("pend_stall", in_ready, 1'b0);
    idle(0, 0);
    idle(0, 0);
    check("pend_hold", out_data, 4'b0000);
    idle(0, 1);
    check("pend_data", out_data, 4'b0001);
    check("pend_nbits", out_nbits, 3'd2);
    idle(0, 1);

    // Reset mid-channel with a held word
    for (int i = 0; i < 4; i++) drive(1, 10, 1, 7, 0, 0, 0);
    drive(1, 1000, 0, 0, 0, 0, 0);
    drive(1, 1000, 0, 0, 0, 0, 0);
    pulse_reset();
    drive(1, 5, 0, 11, 1, 0, 0);
    drive(1, 5, 1, 11, 1, 0, 0);
    idle(1, 0);
    check("post_rst_data", out_data, 4'b0001);
    idle(0, 1);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      if (n == 1000) pulse_reset();
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4608), $urandom_range(0, 2) == 0,
            $urandom_range(0, 11000), $urandom_range(0, 1) == 1,
            $urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0);
    end
    for (int n = 0; n < 4; n++) idle(0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
